ahb_sram_slave: RTL

Synthesizable AHB-Lite slave backed by an on-chip word-addressed SRAM. It has parametrised data width, depth, base address and a fixed number of wait states per transfer. It returns a two-cycle ERROR response for out-of-range, misaligned and oversized accesses, and forwards write data to a read that immediately follows it. It is the RTL counterpart the AHB agent drives and monitors, and it serves as the default memory target in block and subsystem benches.

---
 rtl/ahb_types_pkg.sv | 38 +++
 rtl/ahb_sram_array.sv | 37 +++
 rtl/ahb_sram_slave.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ahb_types_pkg.sv
// rtl/ahb_types_pkg.sv - AHB-Lite transfer encodings and SRAM slave state type
package ahb_types_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  localparam hresp_t OKAY  = HRESP_OKAY;
  localparam hresp_t ERROR = HRESP_ERROR;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } sram_state_t;

endpackage

// File: rtl/ahb_sram_array.sv
// rtl/ahb_sram_array.sv - synchronous SRAM with byte write enables
// Reads registered; a read of the word being written returns the old contents.
module ahb_sram_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  localparam int unsigned IDX_BITS  = $clog2(DEPTH),
  localparam int unsigned LANES     = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [IDX_BITS-1:0]   i_waddr,
  input  logic [LANES-1:0]      i_wbe,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [IDX_BITS-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite slave fronting a word-addressed on-chip SRAM
// Fixed wait states, two-cycle ERROR, and write-to-read forwarding on the same word.
module ahb_sram_slave
  import ahb_types_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned LANES     = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(LANES);
  localparam int unsigned IDX_BITS  = $clog2(DEPTH);
  localparam int unsigned OFF_BITS  = IDX_BITS + LANE_BITS;
  localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_STATES);

  sram_state_t r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_ready;
  hresp_t      w_resp;

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [7:0]            w_size_mask;
  logic                  w_accept, w_err, w_acc_ok;
  logic [IDX_BITS-1:0]   w_idx;
  logic [LANE_BITS-1:0]  w_lane;
  logic [LANES-1:0]      w_be_base, w_be;

  logic                  r_dp_write, r_dp_read;
  logic [IDX_BITS-1:0]   r_widx;
  logic [LANES-1:0]      r_wbe;
  logic                  r_fwd_en;
  logic [LANES-1:0]      r_fwd_be;
  logic [DATA_WIDTH-1:0] r_fwd_data, r_hrdata;
  logic [DATA_WIDTH-1:0] w_arr_rdata, w_fwd_mask, w_rd_word;
  logic                  w_commit, w_rd_en, w_show;

  assign w_accept = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign w_offset = HADDR - BASE_ADDR;
  assign w_size_mask = (8'd1 << HSIZE) - 8'd1;
  assign w_err = (|w_offset[ADDR_WIDTH-1:OFF_BITS])
               | (|(w_offset[7:0] & w_size_mask))
               | (HSIZE > 3'(LANE_BITS));
  assign w_acc_ok = w_accept & ~w_err;
  assign w_idx  = w_offset[OFF_BITS-1:LANE_BITS];
  assign w_lane = w_offset[LANE_BITS-1:0];

  always_comb begin
    w_be_base = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (i < (1 << HSIZE)) w_be_base[i] = 1'b1;
    end
  end
  assign w_be = w_be_base << w_lane;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Only states with HREADYOUT high may take a new address phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b1;
    w_resp      = OKAY;
    unique case (r_state)
      ST_WAIT: begin
        w_ready = 1'b0;
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_LAST;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        w_ready     = 1'b0;
        w_resp      = ERROR;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: w_resp = ERROR;
      default: ;
    endcase
    if (w_ready) begin
      if (w_accept && w_err) begin
        w_state_nxt = ST_ERR1;
      end else if (w_accept && (WAIT_STATES > 0)) begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = WAIT_CNT;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  assign HREADYOUT = w_ready;
  assign HRESP     = w_resp;

  assign w_commit = w_ready & r_dp_write;
  assign w_rd_en  = w_ready & w_acc_ok & ~HWRITE;
  assign w_show   = w_ready & r_dp_read;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_write <= 1'b0;
      r_dp_read  <= 1'b0;
      r_widx     <= '0;
      r_wbe      <= '0;
      r_fwd_en   <= 1'b0;
      r_fwd_be   <= '0;
      r_fwd_data <= '0;
      r_hrdata   <= '0;
    end else begin
      if (w_ready) begin
        r_dp_write <= w_acc_ok & HWRITE;
        r_dp_read  <= w_acc_ok & ~HWRITE;
        if (w_acc_ok & HWRITE) begin
          r_widx <= w_idx;
          r_wbe  <= w_be;
        end
      end
      // Array returns pre-write data, so keep the committing bytes to merge over it.
      if (w_rd_en) begin
        r_fwd_en   <= w_commit & (w_idx == r_widx);
        r_fwd_be   <= r_wbe;
        r_fwd_data <= HWDATA;
      end
      if (w_show) r_hrdata <= w_rd_word;
    end
  end

  always_comb begin
    w_fwd_mask = '0;
    for (int b = 0; b < int'(LANES); b++) begin
      w_fwd_mask[8*b +: 8] = {8{r_fwd_en & r_fwd_be[b]}};
    end
  end
  assign w_rd_word = (w_arr_rdata & ~w_fwd_mask) | (r_fwd_data & w_fwd_mask);
  assign HRDATA    = w_show ? w_rd_word : r_hrdata;

  ahb_sram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .i_clk  (HCLK),
    .i_we   (w_commit),
    .i_waddr(r_widx),
    .i_wbe  (r_wbe),
    .i_wdata(HWDATA),
    .i_re   (w_rd_en),
    .i_raddr(w_idx),
    .o_rdata(w_arr_rdata)
  );

endmodule
